// File: rtl/bo_pkg.sv
// Shared select encodings for the bo_datapath operative block.
// M0 picks operand A, M1 picks operand B, M2 picks the register write source.
package bo_pkg;

  localparam logic [1:0] SEL_A_RX   = 2'd0;
  localparam logic [1:0] SEL_A_RS   = 2'd1;
  localparam logic [1:0] SEL_A_RH   = 2'd2;
  localparam logic [1:0] SEL_A_K    = 2'd3;

  localparam logic [1:0] SEL_B_RS   = 2'd0;
  localparam logic [1:0] SEL_B_DIN  = 2'd1;
  localparam logic [1:0] SEL_B_RX   = 2'd2;
  localparam logic [1:0] SEL_B_ZERO = 2'd3;

  localparam logic [1:0] SRC_DIN    = 2'd0;
  localparam logic [1:0] SRC_A      = 2'd1;
  localparam logic [1:0] SRC_SUM    = 2'd2;
  localparam logic [1:0] SRC_MUL    = 2'd3;

endpackage

// File: rtl/bo_datapath_if.sv
// Control-word and status bundle between the BC controller (master) and bo_datapath (slave).
interface bo_datapath_if #(
  parameter int W = 8
);
  // No valid/ready pair: the control word is sampled on every clk edge and the
  // datapath never back-pressures; result_valid is a one-cycle strobe with no ready.
  logic         LX;
  logic         LS;
  logic         LH;
  logic         H;
  logic [1:0]   M0;
  logic [1:0]   M1;
  logic [1:0]   M2;
  logic [W-1:0] data_in;
  logic [W-1:0] rx_q;
  logic [W-1:0] rs_q;
  logic [W-1:0] rh_q;
  logic [W-1:0] result;
  logic         result_valid;
  logic         ovf;
  logic [3:0]   busy_cycles;

  modport master (
    output LX, LS, LH, H, M0, M1, M2, data_in,
    input  rx_q, rs_q, rh_q, result, result_valid, ovf, busy_cycles
  );

  modport slave (
    input  LX, LS, LH, H, M0, M1, M2, data_in,
    output rx_q, rs_q, rh_q, result, result_valid, ovf, busy_cycles
  );

endinterface

// File: rtl/bo_alu.sv
// Combinational add/multiply unit with carry/high-bit overflow detection.
// Optional macro BO_SATURATE_EN clamps overflowing results to all-ones instead of wrapping.
module bo_alu
  import bo_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [1:0]   op_i,
  output logic [W-1:0] val_o,
  output logic         ovf_o
);

  logic [W:0]     sum;
  logic [2*W-1:0] prod;
  logic [W-1:0]   raw;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign prod = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};

  // Non-arithmetic ops pass A through and never flag overflow.
  always_comb begin
    raw   = a_i;
    ovf_o = 1'b0;
    case (op_i)
      SRC_SUM: begin
        raw   = sum[W-1:0];
        ovf_o = sum[W];
      end
      SRC_MUL: begin
        raw   = prod[W-1:0];
        ovf_o = |prod[2*W-1:W];
      end
      default: raw = a_i;
    endcase
`ifdef BO_SATURATE_EN
    val_o = ovf_o ? {W{1'b1}} : raw;
`else
    val_o = raw;
`endif
  end

endmodule

// File: rtl/bo_datapath.sv
// Operative block: RX/RS/RH registers, operand muxes, sticky overflow, H-edge logic and busy counter.
// Build option BO_SATURATE_EN (see bo_alu) selects saturating instead of wrapping arithmetic.
module bo_datapath
  import bo_pkg::*;
#(
  parameter int W = 8,
  parameter int K = 1
) (
  input logic          clk,
  input logic          reset,
  bo_datapath_if.slave bus
);

  localparam logic [W-1:0] K_VAL = W'(K);

  logic [W-1:0] rx_q, rx_d;
  logic [W-1:0] rs_q, rs_d;
  logic [W-1:0] rh_q, rh_d;
  logic [W-1:0] result_q, result_d;
  logic         result_valid_q, result_valid_d;
  logic         ovf_q, ovf_d;
  logic         h_q, h_d;
  logic [3:0]   busy_q, busy_d;

  logic [W-1:0] op_a, op_b, alu_val, src;
  logic         alu_ovf, h_rise, h_fall;

  always_comb begin
    op_a = rx_q;
    case (bus.M0)
      SEL_A_RX: op_a = rx_q;
      SEL_A_RS: op_a = rs_q;
      SEL_A_RH: op_a = rh_q;
      default:  op_a = K_VAL;
    endcase
    op_b = rs_q;
    case (bus.M1)
      SEL_B_RS:  op_b = rs_q;
      SEL_B_DIN: op_b = bus.data_in;
      SEL_B_RX:  op_b = rx_q;
      default:   op_b = '0;
    endcase
  end

  bo_alu #(.W(W)) u_alu (
    .a_i   (op_a),
    .b_i   (op_b),
    .op_i  (bus.M2),
    .val_o (alu_val),
    .ovf_o (alu_ovf)
  );

  assign src    = (bus.M2 == SRC_DIN) ? bus.data_in : alu_val;
  assign h_rise = bus.H & ~h_q;
  assign h_fall = ~bus.H & h_q;

  always_comb begin
    rx_d           = bus.LX ? bus.data_in : rx_q;
    rs_d           = bus.LS ? src : rs_q;
    rh_d           = bus.LH ? src : rh_q;
    h_d            = bus.H;
    result_valid_d = h_fall;
    // result captures the post-load RS so a final load in the H-fall cycle is included.
    result_d       = h_fall ? rs_d : result_q;
    // A same-cycle overflow wins over the clear-on-rise.
    ovf_d          = ovf_q;
    if ((bus.LS | bus.LH) & alu_ovf) ovf_d = 1'b1;
    else if (h_rise)                 ovf_d = 1'b0;
    busy_d         = busy_q;
    if (h_rise)                      busy_d = 4'd1;
    else if (bus.H && busy_q != 4'd15) busy_d = busy_q + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_q           <= '0;
      rs_q           <= '0;
      rh_q           <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      ovf_q          <= 1'b0;
      h_q            <= 1'b0;
      busy_q         <= 4'd0;
    end else begin
      rx_q           <= rx_d;
      rs_q           <= rs_d;
      rh_q           <= rh_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      ovf_q          <= ovf_d;
      h_q            <= h_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.rx_q         = rx_q;
  assign bus.rs_q         = rs_q;
  assign bus.rh_q         = rh_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.ovf          = ovf_q;
  assign bus.busy_cycles  = busy_q;

endmodule

// File: tb/tb_bo_datapath.sv
// Self-checking bench for bo_datapath (W=8, K=1): directed spec scenarios plus random
// control words compared against an arithmetic reference model.
module tb_bo_datapath;

  localparam int W = 8;
  localparam int K = 1;
`ifdef BO_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;

  bo_datapath_if #(.W(W)) bus ();

  bo_datapath #(.W(W), .K(K)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  int m_rx, m_rs, m_rh, m_res, m_busy;
  bit m_rv, m_ovf, m_h;

  task automatic model_reset();
    m_rx = 0; m_rs = 0; m_rh = 0; m_res = 0; m_busy = 0;
    m_rv = 0; m_ovf = 0; m_h = 0;
  endtask

  // ---------------- scoreboard check ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("rx_q", 32'(bus.rx_q), 32'(m_rx));
    check_eq("rs_q", 32'(bus.rs_q), 32'(m_rs));
    check_eq("rh_q", 32'(bus.rh_q), 32'(m_rh));
    check_eq("result", 32'(bus.result), 32'(m_res));
    check_eq("result_valid", 32'(bus.result_valid), 32'(m_rv));
    check_eq("ovf", 32'(bus.ovf), 32'(m_ovf));
    check_eq("busy_cycles", 32'(bus.busy_cycles), 32'(m_busy));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_rx"}, 32'(bus.rx_q), 0);
    check_eq({tag, "_rs"}, 32'(bus.rs_q), 0);
    check_eq({tag, "_rh"}, 32'(bus.rh_q), 0);
    check_eq({tag, "_result"}, 32'(bus.result), 0);
    check_eq({tag, "_rv"}, 32'(bus.result_valid), 0);
    check_eq({tag, "_ovf"}, 32'(bus.ovf), 0);
    check_eq({tag, "_busy"}, 32'(bus.busy_cycles), 0);
  endtask

  // ---------------- driver: one control word, one edge ----------------
  // Called at a negedge; drives inputs, advances the model, checks at the next negedge.
  task automatic step(input bit lx, input bit ls, input bit lh, input bit h,
                      input int m0, input int m1, input int m2, input int din);
    int a, b, full, v;
    bit ov, rise, fall;
    bus.LX = lx; bus.LS = ls; bus.LH = lh; bus.H = h;
    bus.M0 = 2'(m0); bus.M1 = 2'(m1); bus.M2 = 2'(m2); bus.data_in = 8'(din);

    case (m0)
      0: a = m_rx;
      1: a = m_rs;
      2: a = m_rh;
      default: a = K;
    endcase
    case (m1)
      0: b = m_rs;
      1: b = din;
      2: b = m_rx;
      default: b = 0;
    endcase
    case (m2)
      0: full = din;
      1: full = a;
      2: full = a + b;
      default: full = a * b;
    endcase
    ov = (m2 >= 2) && (full > 255);
    v  = (ov && SAT) ? 255 : full % 256;
    rise = h && !m_h;
    fall = !h && m_h;

    if ((ls || lh) && ov) m_ovf = 1;
    else if (rise)        m_ovf = 0;
    if (rise)   m_busy = 1;
    else if (h) m_busy = (m_busy < 15) ? m_busy + 1 : 15;
    if (lx) m_rx = din;
    if (ls) m_rs = v;
    if (lh) m_rh = v;
    m_rv = fall;
    if (fall) m_res = m_rs;
    m_h = h;

    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input bit h);
    step(0, 0, 0, h, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.LX = 0; bus.LS = 0; bus.LH = 0; bus.H = 0;
    bus.M0 = 0; bus.M1 = 0; bus.M2 = 0; bus.data_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset_init");
    reset = 1'b1;

    // Load: only RX changes
    step(1, 0, 0, 0, 0, 0, 0, 5);
    check_eq("load_rx", 32'(bus.rx_q), 5);
    check_eq("load_rs_hold", 32'(bus.rs_q), 0);
    check_eq("load_rh_hold", 32'(bus.rh_q), 0);

    // Spec sequence: RX=3, RS=RX*RX=9, RS=RS+din(4)=13, end
    step(1, 0, 0, 1, 0, 0, 0, 3);
    step(0, 1, 0, 1, 0, 2, 3, 0);
    check_eq("seq_mul", 32'(bus.rs_q), 9);
    step(0, 1, 0, 1, 1, 1, 2, 4);
    check_eq("seq_sum", 32'(bus.rs_q), 13);
    idle(0);
    check_eq("seq_result", 32'(bus.result), 13);
    check_eq("seq_valid", 32'(bus.result_valid), 1);
    check_eq("seq_busy", 32'(bus.busy_cycles), 3);
    idle(0);
    check_eq("seq_valid_drop", 32'(bus.result_valid), 0);

    // Overflow: RS=200, RS<=RS+RS
    step(0, 1, 0, 0, 0, 0, 0, 200);
    step(0, 1, 0, 0, 1, 0, 2, 0);
    check_eq("ovf_rs", 32'(bus.rs_q), SAT ? 255 : 144);
    check_eq("ovf_flag", 32'(bus.ovf), 1);

    // Same-cycle H rise and overflow keeps ovf set; a clean rise clears it
    step(0, 1, 0, 0, 0, 0, 0, 200);
    step(0, 1, 0, 1, 1, 0, 2, 0);
    check_eq("rise_ovf_set", 32'(bus.ovf), 1);
    idle(0);
    idle(1);
    check_eq("rise_ovf_clr", 32'(bus.ovf), 0);
    idle(0);

    // Busy counter saturation over 20 H-high cycles
    idle(0);
    for (int i = 0; i < 20; i++) begin
      idle(1);
      check_eq("busy_sat", 32'(bus.busy_cycles), (i + 1 < 15) ? i + 1 : 15);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      idle(0);
      if (bus.result_valid) pulses++;
    end
    check_eq("sat_pulses", 32'(pulses), 1);

    // Random control words with mid-stream async resets
    for (int i = 0; i < 400; i++) begin
      if (i % 97 == 50) begin
        bus.LX = 1'($urandom); bus.LS = 1'($urandom); bus.LH = 1'($urandom);
        bus.H = 1'($urandom);
        bus.M2 = 2'($urandom); bus.data_in = 8'($urandom);
        #2;
        reset = 1'b0;
        #1;
        check_zero("reset_async");
        @(posedge clk);
        @(negedge clk);
        check_zero("reset_hold");
        model_reset();
        reset = 1'b1;
      end else begin
        step(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 255));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
